id_ex_ctrl: RTL

ID_EX_CTRL -- requirements
Module: id_ex_ctrl

---
 rtl/id_ex_ctrl_if.sv | 37 +++
 rtl/id_ex_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_ctrl_if.sv
// ID/EX control bus: ID-stage instruction and pipeline controls in, registered EX controls out.
// The producer (ID/pipeline control side) uses the master modport; the decode block uses slave.
interface id_ex_ctrl_if;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        flush_i;
  logic        ex_stall_i;
  logic        hold_o;
  logic        ex_valid_o;
  logic        ex_reg_write_o;
  logic        ex_mem_read_o;
  logic        ex_mem_write_o;
  logic        ex_mem_to_reg_o;
  logic        ex_alu_src_o;
  logic        ex_branch_o;
  logic [2:0]  ex_aluop_o;
  logic [6:0]  ex_func7_o;
  logic [2:0]  ex_func3_o;
  logic [4:0]  ex_rd_o;
  logic [4:0]  ex_rs1_o;
  logic [4:0]  ex_rs2_o;
  logic [7:0]  illegal_cnt_o;

  modport master (
    output instr_i, instr_valid_i, flush_i, ex_stall_i,
    input  hold_o, ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
           ex_mem_to_reg_o, ex_alu_src_o, ex_branch_o, ex_aluop_o, ex_func7_o,
           ex_func3_o, ex_rd_o, ex_rs1_o, ex_rs2_o, illegal_cnt_o
  );

  modport slave (
    input  instr_i, instr_valid_i, flush_i, ex_stall_i,
    output hold_o, ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
           ex_mem_to_reg_o, ex_alu_src_o, ex_branch_o, ex_aluop_o, ex_func7_o,
           ex_func3_o, ex_rd_o, ex_rs1_o, ex_rs2_o, illegal_cnt_o
  );
endinterface

// File: rtl/id_ex_ctrl.sv
// ID-stage main decoder, load-use hazard detection and ID/EX pipeline register.
// Produces a one-cycle-latency EX control bundle plus a saturating illegal-opcode counter.
module id_ex_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  id_ex_ctrl_if.slave bus
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic             branch;
    logic [2:0]       aluop;
    logic [6:0]       func7;
    logic [2:0]       func3;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE = '0;

  logic [6:0]       opcode;
  logic [2:0]       func3;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic             legal;
  logic             uses_rs2;
  logic             load_use;
  ex_ctrl_t         dec;
  ex_ctrl_t         ex_q;
  ex_ctrl_t         ex_d;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_q;

  assign opcode = bus.instr_i[6:0];
  assign func3  = bus.instr_i[14:12];
  assign rs1    = bus.instr_i[19:15];
  assign rs2    = bus.instr_i[24:20];

  // Opcode decode; illegal encodings leave every control at zero.
  always_comb begin
    dec       = BUBBLE;
    legal     = 1'b0;
    uses_rs2  = 1'b0;
    unique case (opcode)
      OP_R: begin
        legal         = 1'b1;
        uses_rs2      = 1'b1;
        dec.aluop     = 3'b100;
        dec.reg_write = 1'b1;
      end
      OP_I_ALU: begin
        legal         = 1'b1;
        dec.aluop     = 3'b001;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_LOAD: begin
        legal          = 1'b1;
        dec.aluop      = 3'b000;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
      end
      OP_STORE: begin
        legal         = 1'b1;
        uses_rs2      = 1'b1;
        dec.aluop     = 3'b000;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        uses_rs2 = 1'b1;
        if (func3 == 3'b000) begin
          legal      = 1'b1;
          dec.aluop  = 3'b010;
          dec.branch = 1'b1;
        end else if (func3 == 3'b001) begin
          legal      = 1'b1;
          dec.aluop  = 3'b110;
          dec.branch = 1'b1;
        end
      end
      default: begin
        legal = 1'b0;
      end
    endcase
    if (legal) begin
      dec.valid = 1'b1;
      dec.func7 = bus.instr_i[31:25];
      dec.func3 = func3;
      dec.rd    = bus.instr_i[11:7];
      dec.rs1   = rs1;
      dec.rs2   = rs2;
    end else begin
      dec = BUBBLE;
    end
  end

  // A load in EX whose destination feeds the ID instruction forces one bubble.
  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && bus.instr_valid_i &&
                    ((ex_q.rd == rs1) || (uses_rs2 && (ex_q.rd == rs2)));

  assign bus.hold_o = (load_use && !bus.flush_i) || bus.ex_stall_i;

  // Next EX contents: flush > stall > load-use bubble > decoded instruction.
  always_comb begin
    ex_d    = BUBBLE;
    cnt_inc = 1'b0;
    if (bus.flush_i) begin
      ex_d = BUBBLE;
    end else if (bus.ex_stall_i) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = BUBBLE;
    end else if (bus.instr_valid_i) begin
      ex_d    = dec;
      cnt_inc = !legal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.ex_valid_o      = ex_q.valid;
  assign bus.ex_reg_write_o  = ex_q.reg_write;
  assign bus.ex_mem_read_o   = ex_q.mem_read;
  assign bus.ex_mem_write_o  = ex_q.mem_write;
  assign bus.ex_mem_to_reg_o = ex_q.mem_to_reg;
  assign bus.ex_alu_src_o    = ex_q.alu_src;
  assign bus.ex_branch_o     = ex_q.branch;
  assign bus.ex_aluop_o      = ex_q.aluop;
  assign bus.ex_func7_o      = ex_q.func7;
  assign bus.ex_func3_o      = ex_q.func3;
  assign bus.ex_rd_o         = ex_q.rd;
  assign bus.ex_rs1_o        = ex_q.rs1;
  assign bus.ex_rs2_o        = ex_q.rs2;
  assign bus.illegal_cnt_o   = cnt_q;

endmodule
